// File: rtl/instr_buffer_pkg.sv
// ----------------------------------------------------------------------------
// instr_buffer_pkg
//   Types and constants shared by the fetch/predecode side (IF2), the
//   instruction buffer and the decode stage (ID).
//   - ib_entry_t : one queued instruction {pc, instr, pred_taken, pred_target}
//   - RESET_PC   : architectural PC after reset
//   - IB_DEPTH / IB_SKID : default buffer geometry
// ----------------------------------------------------------------------------
package instr_buffer_pkg;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;

   localparam int IB_DEPTH = 8;
   localparam int IB_SKID  = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
      logic [31:0] pred_target;
   } ib_entry_t;

   localparam int IB_ENTRY_W = $bits(ib_entry_t);

endpackage : instr_buffer_pkg

// File: rtl/instr_buffer_mem.sv
// ----------------------------------------------------------------------------
// instr_buffer_mem (ib_mem)
//   Entry storage for the instruction buffer: DEPTH x W register array with
//   one synchronous write port and one asynchronous read port.
//   Contents are not reset; validity is tracked by the buffer's pointers.
//   Ports:
//     clk      in  clock
//     i_we     in  write enable
//     i_waddr  in  write index
//     i_wdata  in  write data (packed ib_entry_t)
//     i_raddr  in  read index
//     o_rdata  out read data, combinational from i_raddr
// ----------------------------------------------------------------------------
module instr_buffer_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 97,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [W-1:0]     i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [W-1:0]     o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : instr_buffer_mem

// File: rtl/instr_buffer.sv
// ----------------------------------------------------------------------------
// instr_buffer
//   In-order instruction queue between fetch/predecode and decode.
//   Single push / single pop per cycle, show-ahead head, flushed in one edge
//   by the EX-stage branch redirect.
//   Ports:
//     clk, rstn                   clock, async active-low reset
//     EX_BR                       redirect: empty the buffer at the next edge
//     push_valid, push_*          entry offered by the fetch side
//     id_ready                    decode consumes the head when dout_valid
//     dout_valid, dout_*          head entry
//     stall_full_instr            count >= DEPTH-SKID; IF1 holds its PC
//     overflow_err                sticky: push seen while the buffer was full
//   Handshake: a push is taken on an edge where push_valid=1, EX_BR=0 and the
//   registered count is below DEPTH (a same-cycle pop does not make room).
//   A pop happens on an edge where dout_valid=1 and id_ready=1. The head
//   stays stable while dout_valid=1 and id_ready=0.
// ----------------------------------------------------------------------------
module instr_buffer
   import instr_buffer_pkg::*;
#(
   parameter int DEPTH = IB_DEPTH,
   parameter int SKID  = IB_SKID
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        EX_BR,
   input  logic        push_valid,
   input  logic [31:0] push_pc,
   input  logic [31:0] push_instr,
   input  logic        push_pred_taken,
   input  logic [31:0] push_pred_target,
   input  logic        id_ready,
   output logic        dout_valid,
   output logic [31:0] dout_pc,
   output logic [31:0] dout_instr,
   output logic        dout_pred_taken,
   output logic [31:0] dout_pred_target,
   output logic        stall_full_instr,
   output logic        overflow_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   localparam logic [PTR_W-1:0] C_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] C_STALL = PTR_W'(DEPTH - SKID);

   // Pointers carry a wrap bit above the index so full/empty are unambiguous.
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_count;
   logic             r_overflow;

   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [PTR_W-1:0] w_count_nxt;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic             w_dout_valid;
   ib_entry_t        w_wr_entry;
   ib_entry_t        w_rd_entry;
   logic [IB_ENTRY_W-1:0] w_rd_bits;

   assign w_full = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[IDX_W]     != r_rd_ptr[IDX_W]);

   assign w_dout_valid = (r_count != '0) & ~EX_BR;
   assign w_push       = push_valid & ~EX_BR & (r_count < C_DEPTH);
   assign w_pop        = w_dout_valid & id_ready;
   // A push against a full buffer means the stall came too late for the
   // fetches in flight; the entry is lost and this is flagged for debug.
   assign w_drop       = push_valid & ~EX_BR & w_full;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (EX_BR) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + C_ONE;
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + C_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      w_wr_entry             = '0;
      w_wr_entry.pc          = push_pc;
      w_wr_entry.instr       = push_instr;
      w_wr_entry.pred_taken  = push_pred_taken;
      w_wr_entry.pred_target = push_pred_target;
   end

   instr_buffer_mem #(
      .DEPTH (DEPTH),
      .W     (IB_ENTRY_W)
   ) u_ib_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[IDX_W-1:0]),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr[IDX_W-1:0]),
      .o_rdata (w_rd_bits)
   );

   assign w_rd_entry = ib_entry_t'(w_rd_bits);

   assign dout_valid       = w_dout_valid;
   assign dout_pc          = w_rd_entry.pc;
   assign dout_instr       = w_rd_entry.instr;
   assign dout_pred_taken  = w_rd_entry.pred_taken;
   assign dout_pred_target = w_rd_entry.pred_target;
   assign stall_full_instr = (r_count >= C_STALL);
   assign overflow_err     = r_overflow;

endmodule : instr_buffer

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
   import instr_buffer_pkg::*;

   localparam int DEPTH = 8;
   localparam int SKID  = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rstn;
   logic        EX_BR;
   logic        push_valid;
   logic [31:0] push_pc;
   logic [31:0] push_instr;
   logic        push_pred_taken;
   logic [31:0] push_pred_target;
   logic        id_ready;
   logic        dout_valid;
   logic [31:0] dout_pc;
   logic [31:0] dout_instr;
   logic        dout_pred_taken;
   logic [31:0] dout_pred_target;
   logic        stall_full_instr;
   logic        overflow_err;

   always #5 clk = ~clk;

   instr_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .EX_BR            (EX_BR),
      .push_valid       (push_valid),
      .push_pc          (push_pc),
      .push_instr       (push_instr),
      .push_pred_taken  (push_pred_taken),
      .push_pred_target (push_pred_target),
      .id_ready         (id_ready),
      .dout_valid       (dout_valid),
      .dout_pc          (dout_pc),
      .dout_instr       (dout_instr),
      .dout_pred_taken  (dout_pred_taken),
      .dout_pred_target (dout_pred_target),
      .stall_full_instr (stall_full_instr),
      .overflow_err     (overflow_err)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic run_chk = 1'b0;

   // Reference contents: {pc, instr, pred_taken, pred_target}, oldest first.
   logic [96:0] exp_q[$];
   logic        m_ovf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the queue model, then advance the model by
   // what the coming edge will do with the inputs now being held.
   always @(negedge clk) begin
      if (run_chk) begin
         if (!rstn) begin
            chk("rst_valid", 32'(dout_valid), 32'd0);
            chk("rst_stall", 32'(stall_full_instr), 32'd0);
            chk("rst_ovf", 32'(overflow_err), 32'd0);
            exp_q.delete();
            m_ovf = 1'b0;
         end else begin
            logic        exp_valid;
            logic [96:0] head;
            int          sz;
            sz        = exp_q.size();
            exp_valid = (sz != 0) && !EX_BR;
            chk("valid", 32'(dout_valid), 32'(exp_valid));
            if (exp_valid) begin
               head = exp_q[0];
               chk("pc", dout_pc, head[96:65]);
               chk("instr", dout_instr, head[64:33]);
               chk("taken", 32'(dout_pred_taken), 32'(head[32]));
               chk("target", dout_pred_target, head[31:0]);
            end
            chk("stall", 32'(stall_full_instr), 32'(sz >= DEPTH - SKID));
            chk("ovf", 32'(overflow_err), 32'(m_ovf));
            if (EX_BR) begin
               exp_q.delete();
            end else begin
               if (push_valid && sz == DEPTH) m_ovf = 1'b1;
               if (exp_valid && id_ready) void'(exp_q.pop_front());
               if (push_valid && sz < DEPTH)
                  exp_q.push_back({push_pc, push_instr, push_pred_taken, push_pred_target});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic pv, input logic [31:0] pc, input logic rdy, input logic br);
      push_valid       = pv;
      push_pc          = pc;
      push_instr       = $urandom;
      push_pred_taken  = 1'($urandom_range(0, 1));
      push_pred_target = $urandom;
      id_ready         = rdy;
      EX_BR            = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rstn = 1'b0;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rstn    = 1'b1;
      run_chk = 1'b1;

      // 1: reset in the middle of a stream
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, RESET_PC + 32'(4 * i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t1_valid_c5", 32'(dout_valid), 32'd1);
      chk("t1_pc_c5", dout_pc, RESET_PC);
      rstn = 1'b0;
      #1;
      chk("t1_valid_rst", 32'(dout_valid), 32'd0);
      chk("t1_stall_rst", 32'(stall_full_instr), 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      chk("t1_valid_after", 32'(dout_valid), 32'd0);

      // 2: fill to the stall threshold, then drain
      for (int i = 0; i < 6; i++) begin
         set_in(1'b1, RESET_PC + 32'(4 * i), 1'b0, 1'b0);
         #1;
         chk("t2_stall_fill", 32'(stall_full_instr), 32'd0);
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b0);
         #1;
         chk("t2_valid", 32'(dout_valid), 32'd1);
         chk("t2_pc", dout_pc, RESET_PC + 32'(4 * i));
         chk("t2_stall", 32'(stall_full_instr), 32'(i == 0));
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t2_empty", 32'(dout_valid), 32'd0);

      // 3: steady push+pop at count 3
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'h1c00_0200 + 32'(4 * i), 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h1c00_020c + 32'(4 * i), 1'b1, 1'b0);
         #1;
         chk("t3_pc", dout_pc, 32'h1c00_0200 + 32'(4 * i));
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b0);
         #1;
         chk("t3_drain_pc", dout_pc, 32'h1c00_0210 + 32'(4 * i));
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t3_empty", 32'(dout_valid), 32'd0);

      // 4: redirect while holding 4 entries and pushing
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h1c00_0080 + 32'(4 * i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 32'h1c00_0100, 1'b1, 1'b1);
      #1;
      chk("t4_valid_br", 32'(dout_valid), 32'd0);
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t4_valid_after", 32'(dout_valid), 32'd0);
      tick();
      set_in(1'b1, 32'h1c00_0300, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("t4_new_head", dout_pc, 32'h1c00_0300);
      tick();

      // 5: stream 20 entries, one push and one pop per cycle
      for (int i = 0; i <= 20; i++) begin
         set_in(1'(i < 20), 32'h1c00_1000 + 32'(4 * i), 1'b1, 1'b0);
         #1;
         if (i > 0) begin
            chk("t5_valid", 32'(dout_valid), 32'd1);
            chk("t5_pc", dout_pc, 32'h1c00_1000 + 32'(4 * (i - 1)));
         end
         tick();
      end

      // 6: ignore the stall, push 9 into 8 slots
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t6_ovf_before", 32'(overflow_err), 32'd0);
      for (int i = 0; i < 9; i++) begin
         set_in(1'b1, 32'h1c00_2000 + 32'(4 * i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t6_ovf", 32'(overflow_err), 32'd1);
      chk("t6_stall", 32'(stall_full_instr), 32'd1);
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b0);
         #1;
         chk("t6_pc", dout_pc, 32'h1c00_2000 + 32'(4 * i));
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("t6_empty", 32'(dout_valid), 32'd0);
      chk("t6_ovf_sticky", 32'(overflow_err), 32'd1);

      // Randomized traffic against the queue model, with periodic resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 600 == 599) begin
            do_reset();
         end else begin
            set_in(1'($urandom_range(0, 99) < 60), $urandom,
                   1'($urandom_range(0, 99) < 50),
                   1'($urandom_range(0, 99) < 3));
            tick();
         end
      end

      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      run_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_instr_buffer
